// File: rtl/blit_pixaddr.sv
// blit_pixaddr: blitter pixel address generator behind the X/Y address adder.
// Maps an (x, y) window pointer to a phrase-relative byte address and bit offset.
module blit_pixaddr #(
  parameter int AW    = 24,
  parameter bit PIPE3 = 1'b1
) (
  input  logic          sys_clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   pix_x,
  input  logic [15:0]   pix_y,
  input  logic [5:0]    width_code,
  input  logic [2:0]    pixsize,
  input  logic [AW-1:0] base_addr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] addr,
  output logic [5:0]    bitoff,
  output logic          err
);

  localparam int BW = AW - 3;

  // Input decode and the shift-add y*(4+m) product
  logic [3:0]  in_e;
  logic [1:0]  in_m;
  logic [1:0]  m_eff;
  logic [2:0]  in_ps;
  logic [18:0] in_ym;

  always_comb begin
    in_e  = width_code[5:2];
    in_m  = width_code[1:0];
    in_ps = (pixsize >= 3'd6) ? 3'd5 : pixsize;
    // For e<2 the >>2 in W drops mantissa bits; masking them keeps (ym<<e)>>2 == y*W.
    if (in_e == 4'd0)      m_eff = 2'b00;
    else if (in_e == 4'd1) m_eff = {in_m[1], 1'b0};
    else                   m_eff = in_m;
    in_ym = 19'({pix_y, 2'b00})
          + (m_eff[0] ? 19'(pix_y)          : 19'd0)
          + (m_eff[1] ? 19'({pix_y, 1'b0})  : 19'd0);
  end

  // Stage 1
  logic          s1_v;
  logic [18:0]   s1_ym;
  logic [15:0]   s1_x;
  logic [3:0]    s1_e;
  logic [2:0]    s1_ps;
  logic [BW-1:0] s1_base;
  logic          s1_err;
  logic          adv1;
  logic          adv2;

  assign adv1     = !s1_v || adv2;
  assign in_ready = adv1;

  always_ff @(posedge sys_clk or posedge reset) begin
    // NOTE: data registers are reset too, so addr/bitoff/err read 0 while in reset.
    if (reset) begin
      s1_v    <= 1'b0;
      s1_ym   <= '0;
      s1_x    <= '0;
      s1_e    <= '0;
      s1_ps   <= '0;
      s1_base <= '0;
      s1_err  <= 1'b0;
    end else if (adv1) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_ym   <= in_ym;
        s1_x    <= pix_x;
        s1_e    <= in_e;
        s1_ps   <= in_ps;
        s1_base <= base_addr[AW-1:3];
        s1_err  <= (pixsize >= 3'd6);
      end
    end
  end

  // Linear pixel index from stage-1 state
  logic [33:0] ym_sh;
  logic [31:0] p_comb;

  assign ym_sh  = 34'(s1_ym) << s1_e;
  assign p_comb = ym_sh[33:2] + 32'(s1_x);

  // Last stage: holds the bit address B and drives the outputs
  logic          lst_v;
  logic [31:0]   lst_b;
  logic [BW-1:0] lst_base;
  logic          lst_err;

  if (PIPE3) begin : g_pipe3
    logic          s2_v;
    logic [31:0]   s2_p;
    logic [2:0]    s2_ps;
    logic [BW-1:0] s2_base;
    logic          s2_err;
    logic          adv3;

    assign adv3 = !lst_v || out_ready;
    assign adv2 = !s2_v || adv3;

    always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
        s2_v    <= 1'b0;
        s2_p    <= '0;
        s2_ps   <= '0;
        s2_base <= '0;
        s2_err  <= 1'b0;
      end else if (adv2) begin
        s2_v <= s1_v;
        if (s1_v) begin
          s2_p    <= p_comb;
          s2_ps   <= s1_ps;
          s2_base <= s1_base;
          s2_err  <= s1_err;
        end
      end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
        lst_v    <= 1'b0;
        lst_b    <= '0;
        lst_base <= '0;
        lst_err  <= 1'b0;
      end else if (adv3) begin
        lst_v <= s2_v;
        if (s2_v) begin
          lst_b    <= s2_p << s2_ps;
          lst_base <= s2_base;
          lst_err  <= s2_err;
        end
      end
    end
  end else begin : g_pipe2
    assign adv2 = !lst_v || out_ready;

    always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
        lst_v    <= 1'b0;
        lst_b    <= '0;
        lst_base <= '0;
        lst_err  <= 1'b0;
      end else if (adv2) begin
        lst_v <= s1_v;
        if (s1_v) begin
          lst_b    <= p_comb << s1_ps;
          lst_base <= s1_base;
          lst_err  <= s1_err;
        end
      end
    end
  end

  // Byte address wraps modulo 2^AW; B[AW+2:3] is zero-extended when AW+3 > 32
  logic [AW+2:0] b_ext;

  assign b_ext     = (AW+3)'(lst_b);
  assign addr      = {lst_base, 3'b000} + b_ext[AW+2:3];
  assign bitoff    = lst_b[5:0];
  assign err       = lst_err;
  assign out_valid = lst_v;

  logic unused_bits;
  assign unused_bits = &{1'b0, base_addr[2:0], ym_sh[1:0]};

endmodule

// File: tb/tb_blit_pixaddr.sv
// tb_blit_pixaddr: directed vectors with hand-computed addresses for blit_pixaddr.
// A scoreboard queue holds the expected results of accepted transactions in order.
module tb_blit_pixaddr;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] pix_x;
  logic [15:0] pix_y;
  logic [5:0]  width_code;
  logic [2:0]  pixsize;
  logic [23:0] base_addr;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] addr;
  logic [5:0]  bitoff;
  logic        err;

  blit_pixaddr #(.AW(24), .PIPE3(1'b1)) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .width_code (width_code),
    .pixsize    (pixsize),
    .base_addr  (base_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .addr       (addr),
    .bitoff     (bitoff),
    .err        (err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [5:0]  wc;
    logic [2:0]  ps;
    logic [23:0] base;
    logic [23:0] addr;
    logic [5:0]  bo;
    logic        err;
  } vec_t;

  typedef struct packed {
    logic [23:0] addr;
    logic [5:0]  bo;
    logic        err;
  } res_t;

  res_t exp_q[$];
  res_t cur_exp;
  int   emit_cyc[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   n_out = 0;
  bit   last_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] x, input logic [15:0] y,
                              input logic [5:0] wc, input logic [2:0] ps,
                              input logic [23:0] base, input logic [23:0] a,
                              input logic [5:0] bo, input logic e);
    vec_t v;
    v.x = x; v.y = y; v.wc = wc; v.ps = ps; v.base = base;
    v.addr = a; v.bo = bo; v.err = e;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    pix_x      = v.x;
    pix_y      = v.y;
    width_code = v.wc;
    pixsize    = v.ps;
    base_addr  = v.base;
    cur_exp    = '{addr: v.addr, bo: v.bo, err: v.err};
    in_valid   = 1'b1;
  endtask

  // One clock: score handshakes at the falling edge, then advance past the rising edge.
  task automatic tick();
    res_t r;
    @(negedge sys_clk);
    last_acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'd1, 32'd0);
      end else begin
        r = exp_q.pop_front();
        check($sformatf("addr#%0d", n_out), 32'(addr), 32'(r.addr));
        check($sformatf("bitoff#%0d", n_out), 32'(bitoff), 32'(r.bo));
        check($sformatf("err#%0d", n_out), 32'(err), 32'(r.err));
      end
      n_out++;
      emit_cyc.push_back(cyc);
    end
    if (last_acc) exp_q.push_back(cur_exp);
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  vec_t v_t1;
  vec_t v_st[8];
  vec_t v_t3[5];
  vec_t v_t4[2];
  vec_t v_t5[3];
  int   bo_tab[8] = '{0, 40, 16, 56, 32, 8, 48, 24};

  initial begin
    int k;
    int n;
    res_t hold;

    // y=3,x=5, W=96 -> P=293, B=4688
    v_t1 = mk(16'd5, 16'd3, 6'h1A, 3'd4, 24'h001000, 24'h00124A, 6'd16, 1'b0);
    // W=4, 8bpp, x=y=i -> P=5i, B=40i
    for (int i = 0; i < 8; i++)
      v_st[i] = mk(16'(i), 16'(i), 6'h08, 3'd3, 24'h000100, 24'h000100 + 24'(5 * i),
                   6'(bo_tab[i]), 1'b0);
    v_t3[0] = mk(16'd3, 16'd10, 6'h05, 3'd0, 24'h000000, 24'h000002, 6'd23, 1'b0);
    v_t3[1] = mk(16'd2, 16'd7, 6'h03, 3'd3, 24'h000040, 24'h000049, 6'd8, 1'b0);
    v_t3[2] = mk(16'd1, 16'd2, 6'h0D, 3'd5, 24'h000800, 24'h000854, 6'd32, 1'b0);
    v_t3[3] = mk(16'd0, 16'd100, 6'h3F, 3'd2, 24'h000000, 24'h2BC000, 6'd0, 1'b0);
    v_t3[4] = mk(16'd0, 16'hFFFF, 6'h0B, 3'd0, 24'h000000, 24'h00DFFF, 6'd57, 1'b0);
    v_t4[0] = mk(16'd4, 16'd0, 6'h08, 3'd5, 24'hFFFFF8, 24'h000008, 6'd0, 1'b0);
    v_t4[1] = mk(16'd0, 16'd0, 6'h08, 3'd0, 24'h000107, 24'h000100, 6'd0, 1'b0);
    v_t5[0] = mk(16'd1, 16'd0, 6'h08, 3'd7, 24'h000000, 24'h000004, 6'd32, 1'b1);
    v_t5[1] = mk(16'd3, 16'd0, 6'h08, 3'd6, 24'h000000, 24'h00000C, 6'd32, 1'b1);
    v_t5[2] = mk(16'd2, 16'd0, 6'h08, 3'd3, 24'h000000, 24'h000002, 6'd16, 1'b0);

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    pix_x = '0; pix_y = '0; width_code = '0; pixsize = '0; base_addr = '0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_bitoff", 32'(bitoff), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    #1 reset = 1'b0;
    @(posedge sys_clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Test 1: single transaction and its latency
    drive(v_t1);
    check("t1_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("t1_lat1", 32'(out_valid), 32'd0);
    tick();
    check("t1_lat2", 32'(out_valid), 32'd0);
    tick();
    check("t1_lat3", 32'(out_valid), 32'd1);
    drain("t1", 5);

    // Test 2: streaming with out_ready held high
    emit_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      drive(v_st[i]);
      check($sformatf("t2_in_ready%0d", i), 32'(in_ready), 32'd1);
      tick();
    end
    drain("t2", 10);
    check("t2_count", 32'(emit_cyc.size()), 32'd8);
    check("t2_span", (emit_cyc.size() > 0) ? 32'(emit_cyc[emit_cyc.size()-1] - emit_cyc[0]) : 32'hFFFF_FFFF,
          32'd7);

    // Test 3: back-pressure for 6 cycles while offering 5 transactions
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      if (k < 5) drive(v_t3[k]);
      if (out_valid && exp_q.size() != 0) begin
        hold = exp_q[0];
        check("t3_hold_addr", 32'(addr), 32'(hold.addr));
        check("t3_hold_bitoff", 32'(bitoff), 32'(hold.bo));
      end
      tick();
      if (last_acc) k++;
    end
    check("t3_accepted", 32'(k), 32'd3);
    check("t3_in_ready_low", 32'(in_ready), 32'd0);
    check("t3_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    n = 0;
    while (k < 5 && n < 20) begin
      drive(v_t3[k]);
      tick();
      if (last_acc) k++;
      n++;
    end
    check("t3_all_accepted", 32'(k), 32'd5);
    drain("t3", 10);

    // Test 4: base wrap and ignored low base bits
    for (int i = 0; i < 2; i++) begin
      drive(v_t4[i]);
      tick();
    end
    drain("t4", 10);

    // Test 5: illegal pixel sizes behave as 32bpp and flag err
    for (int i = 0; i < 3; i++) begin
      drive(v_t5[i]);
      tick();
    end
    drain("t5", 10);

    // Test 6: asynchronous reset with the pipe full
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(v_st[i]);
      tick();
    end
    in_valid = 1'b0;
    check("t6_full", 32'(in_ready), 32'd0);
    check("t6_pre_valid", 32'(out_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t6_async_valid", 32'(out_valid), 32'd0);
    check("t6_async_addr", 32'(addr), 32'd0);
    check("t6_async_bitoff", 32'(bitoff), 32'd0);
    exp_q.delete();
    out_ready = 1'b1;
    #3 reset = 1'b0;
    @(posedge sys_clk);
    #1;
    check("t6_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t6_no_stale%0d", i), 32'(out_valid), 32'd0);
      tick();
    end
    drive(v_t1);
    tick();
    drain("t6", 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
